// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly; 11 edges capture-to-valid, 12-cycle block rate.
// No backpressure: a start is taken only while idle, inputs are ignored while busy, and valid is a single-cycle strobe.
module aes128_iter_encrypt #(
    parameter int NR = 10
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] DONE_ROUND = 4'(NR + 1);

    fsm_t         fsm;
    fsm_t         fsm_nxt;
    logic [127:0] aes_state;
    logic [127:0] rkey;
    logic [3:0]   round;

    logic         load;
    logic         step;
    logic         done;
    logic [127:0] next_rkey;
    logic [127:0] shifted;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as b^254 (product of b^2 .. b^128), then the forward affine map; 0 maps to 0 before the affine.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n sits at bits [127-8n -: 8]; row r of column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) fsm <= IDLE;
        else            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (AES_en) fsm_nxt = BUSY;
            BUSY:    if (round == DONE_ROUND) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Round NR+1 is an output-only cycle so the round logic never drives the output register.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        done = 1'b0;
        case (fsm)
            IDLE: load = AES_en;
            BUSY: begin
                step = (round <= LAST_ROUND);
                done = (round == DONE_ROUND);
            end
            default: ;
        endcase
    end

    always_comb begin
        next_rkey = key_expand(rkey, rcon(round));
        shifted   = shift_rows(sub_bytes(aes_state));
        round_out = (round == LAST_ROUND) ? (shifted ^ next_rkey)
                                          : (mix_columns(shifted) ^ next_rkey);
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            aes_state <= '0;
            rkey      <= '0;
            round     <= '0;
        end else if (load) begin
            aes_state <= AES_data_in ^ AES_key_in;
            rkey      <= AES_key_in;
            round     <= 4'd1;
        end else if (step) begin
            aes_state <= round_out;
            rkey      <= next_rkey;
            round     <= round + 4'd1;
        end else if (done) begin
            aes_state <= '0;
            rkey      <= '0;
            round     <= '0;
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= done;
            if (done) AES_data_out <= aes_state;
        end
    end

endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Scoreboarded bench for the iterative AES-128 encryptor.
module tb_aes128_iter_encrypt;

    logic         AES_clk;
    logic         AES_rst_n;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    aes128_iter_encrypt #(.NR(10)) dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
    );

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_x;
    int           vectors = 0;
    int           errors  = 0;
    int           cyc     = 0;
    int           pulses  = 0;
    logic [127:0] last_out = '0;
    logic [7:0]   sbox_tb[256];

    initial AES_clk = 1'b0;
    always #5 AES_clk = ~AES_clk;

    always @(posedge AES_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // S-box built by walking the multiplicative group with generator 3 and its inverse.
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tb[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w[44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   st[16];
        logic [7:0]   tmp[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]], sbox_tb[t[31:24]]} ^ {rc, 24'h0};
                rc = mul2(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_tb[st[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++) begin
                a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
                if (r == 10) begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end else begin
                    st[4*c]   = mul2(a0) ^ (mul2(a1) ^ a1) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ mul2(a1) ^ (mul2(a2) ^ a2) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ (mul2(a3) ^ a3);
                    st[4*c+3] = (mul2(a0) ^ a0) ^ a1 ^ a2 ^ mul2(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    always @(negedge AES_clk) begin
        if (AES_rst_n) begin
            if (AES_data_out_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("spurious_valid", {127'b0, AES_data_out_valid}, 128'd0);
                end else begin
                    mon_x = sb.pop_front();
                    check("ciphertext", AES_data_out, mon_x.ct);
                    check("latency", cyc, mon_x.due);
                end
                last_out = AES_data_out;
            end else begin
                check("hold", AES_data_out, last_out);
            end
        end
    end

    task automatic start_op(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
        @(negedge AES_clk);
        AES_key_in  = k;
        AES_data_in = p;
        AES_en      = 1'b1;
        sb.push_back('{e, cyc + 12});
        @(negedge AES_clk);
        AES_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge AES_clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge AES_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k, p, e;
        int p0, base;
        AES_rst_n   = 1'b0;
        AES_en      = 1'b0;
        AES_data_in = '0;
        AES_key_in  = '0;
        init_sbox();
        repeat (3) @(negedge AES_clk);
        check("rst_data_out", AES_data_out, 128'd0);
        check("rst_valid", {127'b0, AES_data_out_valid}, 128'd0);
        AES_rst_n = 1'b1;
        repeat (2) @(negedge AES_clk);

        start_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drain(40);
        start_op(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                 128'h3925841d02dc09fbdc118597196a0b32);
        drain(40);
        start_op(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        drain(40);

        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            start_op(k, p, ref_encrypt(k, p));
            drain(40);
        end

        // Inputs move with the start request low: nothing should come out.
        @(negedge AES_clk);
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
        repeat (25) @(negedge AES_clk);

        // Inputs and a fresh start request change while busy.
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, p, ref_encrypt(k, p));
        AES_data_in = ~p;
        AES_key_in  = ~k;
        AES_en      = 1'b1;
        repeat (3) @(negedge AES_clk);
        AES_en = 1'b0;
        drain(40);

        // Start held high for 51 edges: captures on edges 1, 13, 25, 37 and 49.
        k = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        p = 128'h00000025000000000000000000000000;
        e = ref_encrypt(k, p);
        p0 = pulses;
        @(negedge AES_clk);
        base = cyc;
        AES_key_in  = k;
        AES_data_in = p;
        AES_en      = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{e, base + 12 + 12*i});
        repeat (51) @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en      = 1'b0;
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        drain(60);
        repeat (30) @(negedge AES_clk);
        check("hold_pulses", pulses - p0, 5);

        // Reset while in round 5 discards the block.
        start_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        repeat (4) @(negedge AES_clk);
        #2;
        AES_rst_n = 1'b0;
        sb.delete();
        last_out = '0;
        #1;
        check("midrst_data_out", AES_data_out, 128'd0);
        check("midrst_valid", {127'b0, AES_data_out_valid}, 128'd0);
        repeat (3) @(negedge AES_clk);
        #2;
        AES_rst_n = 1'b1;
        p0 = pulses;
        repeat (20) @(negedge AES_clk);
        check("post_rst_pulses", pulses - p0, 0);
        start_op(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drain(40);

        repeat (5) @(negedge AES_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
